// File: rtl/div_issue_seq_if.sv
// div_issue_seq_if: bundles the operand stream, the result stream and the
// handshake with the iterative divider used by div_issue_seq.
// The slave modport is the sequencer's view; the master modport is the view of
// everything around it (operand producer, result consumer and the divider).
interface div_issue_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_by_zero;

  logic             div_go;
  logic [WIDTH-1:0] div_left;
  logic [WIDTH-1:0] div_right;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport slave (
    input  in_valid, in_left, in_right,
    output in_ready,
    output out_valid, out_quotient, out_remainder, out_div_by_zero,
    input  out_ready,
    output div_go, div_left, div_right,
    input  div_done, div_quotient, div_remainder
  );

  modport master (
    output in_valid, in_left, in_right,
    input  in_ready,
    input  out_valid, out_quotient, out_remainder, out_div_by_zero,
    output out_ready,
    input  div_go, div_left, div_right,
    output div_done, div_quotient, div_remainder
  );
endinterface

// File: rtl/div_issue_seq.sv
// div_issue_seq: turns the multi-cycle iterative divider into a stream stage.
// Operand pairs are buffered in a small FIFO, issued one at a time with a
// single-cycle go pulse, and the divider's result is held on a valid/ready
// output until the consumer takes it.
// Optional feature macro: DIV_SEQ_ZERO_BYPASS_EN -- when defined, an operand
// pair with a zero divisor never reaches the divider; the result (all-ones
// quotient, dividend as remainder) is produced directly.
module div_issue_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  div_issue_seq_if.slave bus,
  output logic           busy
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] fifo_left  [DEPTH];
  logic [WIDTH-1:0] fifo_right [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic [WIDTH-1:0] op_left;
  logic [WIDTH-1:0] op_right;
  logic [WIDTH-1:0] res_quotient;
  logic [WIDTH-1:0] res_remainder;
  logic             res_div_by_zero;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass_pop;
  logic capture_done;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Input is refused while reset is asserted so nothing slips in during it.
  assign bus.in_ready = !reset && !full;
  assign push         = bus.in_valid && bus.in_ready;

  // Only an idle sequencer takes the next operand pair; one op outstanding.
  assign pop = (state == IDLE) && !empty;

`ifdef DIV_SEQ_ZERO_BYPASS_EN
  logic head_zero;
  assign head_zero  = (fifo_right[rd_ptr] == '0);
  assign bypass_pop = pop && head_zero;
`else
  assign bypass_pop = 1'b0;
`endif

  assign busy = !empty || (state != IDLE);

  // Operand storage; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_left[wr_ptr]  <= bus.in_left;
      fifo_right[wr_ptr] <= bus.in_right;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the per-state handshake outputs.
  always_comb begin
    state_next    = state;
    bus.div_go    = 1'b0;
    bus.out_valid = 1'b0;
    capture_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bypass_pop) begin
          state_next = HOLD;
        end else if (pop) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bus.div_go = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.div_done) begin
          capture_done = 1'b1;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand registers feed the divider and only change when an entry is popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_left  <= '0;
      op_right <= '0;
    end else if (pop) begin
      op_left  <= fifo_left[rd_ptr];
      op_right <= fifo_right[rd_ptr];
    end
  end

  assign bus.div_left  = op_left;
  assign bus.div_right = op_right;

  // Result registers: loaded from the divider on done, or directly on a bypassed pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_quotient    <= '0;
      res_remainder   <= '0;
      res_div_by_zero <= 1'b0;
    end else if (capture_done) begin
      res_quotient    <= bus.div_quotient;
      res_remainder   <= bus.div_remainder;
      res_div_by_zero <= (op_right == '0);
    end else if (bypass_pop) begin
      res_quotient    <= '1;
      res_remainder   <= fifo_left[rd_ptr];
      res_div_by_zero <= 1'b1;
    end
  end

  assign bus.out_quotient    = res_quotient;
  assign bus.out_remainder   = res_remainder;
  assign bus.out_div_by_zero = res_div_by_zero;

endmodule

// File: tb/tb_div_issue_seq.sv
// tb_div_issue_seq: directed bench for div_issue_seq with a divider responder,
// a queue-based result model checked every cycle, and hand-computed checks.
module tb_div_issue_seq;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 4;
  localparam int RESP_DELAY = 8;
  localparam logic [7:0] ZERO_Q = 8'hAA;
  localparam logic [7:0] ZERO_R = 8'h55;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } result_t;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  logic       respDone  = 1'b0;
  logic       strayDone = 1'b0;
  logic [7:0] respQ     = 8'h00;
  logic [7:0] respR     = 8'h00;

  int checkCount = 0;
  int passCount  = 0;

  result_t expQ[$];
  op_t     issueQ[$];
  logic    prevGo      = 1'b0;
  logic    expectValid = 1'b0;
  logic    inflight    = 1'b0;

  div_issue_seq_if #(.WIDTH(WIDTH)) bus ();

  div_issue_seq #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  assign bus.div_done      = respDone | strayDone;
  assign bus.div_quotient  = respQ;
  assign bus.div_remainder = respR;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // What the sequencer must present for an accepted operand pair.
  function automatic result_t modelResult(input logic [7:0] l, input logic [7:0] r);
    result_t res;
    if (r == 8'd0) begin
`ifdef DIV_SEQ_ZERO_BYPASS_EN
      res.q = 8'hFF;
      res.r = l;
`else
      res.q = ZERO_Q;
      res.r = ZERO_R;
`endif
      res.dbz = 1'b1;
    end else begin
      res.q   = l / r;
      res.r   = l % r;
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  function automatic bit reachesDivider(input logic [7:0] r);
`ifdef DIV_SEQ_ZERO_BYPASS_EN
    return (r != 8'd0);
`else
    return 1'b1;
`endif
  endfunction

  // Divider stand-in: answers each go pulse RESP_DELAY cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.div_go && !reset) begin
        if (bus.div_right == 8'd0) begin
          respQ = ZERO_Q;
          respR = ZERO_R;
        end else begin
          respQ = bus.div_left / bus.div_right;
          respR = bus.div_left % bus.div_right;
        end
        repeat (RESP_DELAY) @(posedge clk);
        #1 respDone = 1'b1;
        @(posedge clk);
        #1 respDone = 1'b0;
      end
    end
  end

  // Every-cycle comparison of the DUT against the queue model.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      issueQ.delete();
      prevGo      = 1'b0;
      expectValid = 1'b0;
      inflight    = 1'b0;
    end else begin
      if (expectValid) begin
        checkOutput("valid_one_after_done", bus.out_valid, 1'b1);
      end
      expectValid = inflight && !bus.out_valid && bus.div_done && !bus.div_go;
      if (bus.div_go) begin
        checkOutput("go_single_cycle", prevGo, 1'b0);
        checkOutput("go_one_outstanding", inflight, 1'b0);
        checkOutput("go_has_queued_op", issueQ.size() != 0, 1'b1);
        if (issueQ.size() != 0) begin
          checkOutput("go_div_left", bus.div_left, issueQ[0].l);
          checkOutput("go_div_right", bus.div_right, issueQ[0].r);
          void'(issueQ.pop_front());
        end
        inflight = 1'b1;
      end
      prevGo = bus.div_go;
      if (bus.out_valid) begin
        checkOutput("result_pending", expQ.size() != 0, 1'b1);
        if (expQ.size() != 0) begin
          checkOutput("model_quotient", bus.out_quotient, expQ[0].q);
          checkOutput("model_remainder", bus.out_remainder, expQ[0].r);
          checkOutput("model_div_by_zero", bus.out_div_by_zero, expQ[0].dbz);
          if (bus.out_ready) begin
            void'(expQ.pop_front());
            inflight = 1'b0;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(modelResult(bus.in_left, bus.in_right));
        if (reachesDivider(bus.in_right)) begin
          issueQ.push_back('{l: bus.in_left, r: bus.in_right});
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and hold it until accepted; returns 1 ns after the push edge.
  task automatic applyStimulus(input logic [7:0] l, input logic [7:0] r);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_left  = l;
    bus.in_right = r;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput("push_accepted", bus.in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(input string name, input int maxCycles);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.out_valid, 1'b1);
  endtask

  task automatic waitGo(input string name, input int maxCycles);
    int n = 0;
    @(negedge clk);
    while (!bus.div_go && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.div_go, 1'b1);
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n = 0;
    @(negedge clk);
    while (busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, busy, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 1'b1);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 1'b0);
    checkOutput({tag, "_out_quotient"}, bus.out_quotient, 8'h00);
    checkOutput({tag, "_out_remainder"}, bus.out_remainder, 8'h00);
    checkOutput({tag, "_out_div_by_zero"}, bus.out_div_by_zero, 1'b0);
    checkOutput({tag, "_div_go"}, bus.div_go, 1'b0);
    checkOutput({tag, "_div_left"}, bus.div_left, 8'h00);
    checkOutput({tag, "_div_right"}, bus.div_right, 8'h00);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_left   = 8'h00;
    bus.in_right  = 8'h00;
    bus.out_ready = 1'b0;
    reset         = 1'b1;

    @(negedge clk);
    checkOutput("in_ready_in_reset", bus.in_ready, 1'b0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    $display("[TB] single op 100/7");
    nextCycle();
    applyStimulus(8'd100, 8'd7);
    @(negedge clk);
    checkOutput("single_go_not_yet", bus.div_go, 1'b0);
    checkOutput("single_busy", busy, 1'b1);
    @(negedge clk);
    checkOutput("single_go", bus.div_go, 1'b1);
    checkOutput("single_div_left", bus.div_left, 8'd100);
    checkOutput("single_div_right", bus.div_right, 8'd7);
    @(negedge clk);
    checkOutput("single_go_dropped", bus.div_go, 1'b0);
    repeat (RESP_DELAY - 1) @(negedge clk);
    checkOutput("single_valid_not_early", bus.out_valid, 1'b0);
    @(negedge clk);
    checkOutput("single_valid", bus.out_valid, 1'b1);
    checkOutput("single_quotient", bus.out_quotient, 8'd14);
    checkOutput("single_remainder", bus.out_remainder, 8'd2);
    checkOutput("single_div_by_zero", bus.out_div_by_zero, 1'b0);

    $display("[TB] back-pressure with two queued ops");
    nextCycle();
    applyStimulus(8'd200, 8'd9);
    applyStimulus(8'd55, 8'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", bus.out_valid, 1'b1);
      checkOutput("bp_quotient_held", bus.out_quotient, 8'd14);
      checkOutput("bp_no_go", bus.div_go, 1'b0);
    end
    nextCycle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_at_handshake", bus.out_valid, 1'b1);
    @(negedge clk);
    checkOutput("bp_valid_released", bus.out_valid, 1'b0);
    checkOutput("bp_go_not_yet", bus.div_go, 1'b0);
    @(negedge clk);
    checkOutput("bp_next_go", bus.div_go, 1'b1);
    checkOutput("bp_next_left", bus.div_left, 8'd200);
    checkOutput("bp_next_right", bus.div_right, 8'd9);
    waitIdle("bp_drained", 200);

    $display("[TB] FIFO full while an op is in the divider");
    nextCycle();
    applyStimulus(8'd50, 8'd3);
    waitGo("full_first_go", 20);
    nextCycle();
    applyStimulus(8'd81, 8'd9);
    applyStimulus(8'd250, 8'd7);
    applyStimulus(8'd17, 8'd4);
    applyStimulus(8'd64, 8'd8);
    @(negedge clk);
    checkOutput("full_in_ready_low", bus.in_ready, 1'b0);
    checkOutput("full_busy", busy, 1'b1);
    nextCycle();
    applyStimulus(8'd99, 8'd10);
    waitIdle("full_drained", 400);
    checkOutput("full_all_results_seen", expQ.size(), 0);

    $display("[TB] zero divisor 9/0");
    bus.out_ready = 1'b0;
    nextCycle();
    applyStimulus(8'd9, 8'd0);
    @(negedge clk);
    checkOutput("zero_go_pop_cycle", bus.div_go, 1'b0);
`ifdef DIV_SEQ_ZERO_BYPASS_EN
    @(negedge clk);
    checkOutput("zero_no_go", bus.div_go, 1'b0);
    checkOutput("zero_valid_after_pop", bus.out_valid, 1'b1);
    checkOutput("zero_quotient", bus.out_quotient, 8'hFF);
    checkOutput("zero_remainder", bus.out_remainder, 8'd9);
`else
    @(negedge clk);
    checkOutput("zero_go_issued", bus.div_go, 1'b1);
    checkOutput("zero_go_right", bus.div_right, 8'd0);
    waitValid("zero_valid", 20);
    checkOutput("zero_quotient", bus.out_quotient, 8'hAA);
    checkOutput("zero_remainder", bus.out_remainder, 8'h55);
`endif
    checkOutput("zero_div_by_zero", bus.out_div_by_zero, 1'b1);
    nextCycle();
    bus.out_ready = 1'b1;
    waitIdle("zero_drained", 20);

    $display("[TB] stray done in HOLD and IDLE");
    bus.out_ready = 1'b0;
    nextCycle();
    applyStimulus(8'd20, 8'd6);
    waitValid("stray_valid", 30);
    nextCycle();
    strayDone = 1'b1;
    nextCycle();
    strayDone = 1'b0;
    @(negedge clk);
    checkOutput("stray_hold_valid", bus.out_valid, 1'b1);
    checkOutput("stray_hold_quotient", bus.out_quotient, 8'd3);
    checkOutput("stray_hold_remainder", bus.out_remainder, 8'd2);
    checkOutput("stray_hold_no_go", bus.div_go, 1'b0);
    nextCycle();
    bus.out_ready = 1'b1;
    waitIdle("stray_drained", 20);
    nextCycle();
    strayDone = 1'b1;
    nextCycle();
    strayDone = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("stray_idle_valid", bus.out_valid, 1'b0);
      checkOutput("stray_idle_busy", busy, 1'b0);
      checkOutput("stray_idle_no_go", bus.div_go, 1'b0);
      checkOutput("stray_idle_quotient", bus.out_quotient, 8'd3);
    end

    $display("[TB] reset while waiting on the divider");
    nextCycle();
    applyStimulus(8'd77, 8'd7);
    applyStimulus(8'd30, 8'd4);
    applyStimulus(8'd40, 8'd5);
    @(negedge clk);
    checkOutput("rst_busy_before", busy, 1'b1);
    checkOutput("rst_op_left_before", bus.div_left, 8'd77);
    checkOutput("rst_op_right_before", bus.div_right, 8'd7);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready_low", bus.in_ready, 1'b0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("midwait");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("rst_late_done_valid", bus.out_valid, 1'b0);
      checkOutput("rst_late_done_go", bus.div_go, 1'b0);
    end
    nextCycle();
    applyStimulus(8'd12, 8'd4);
    waitValid("rst_fresh_valid", 30);
    checkOutput("rst_fresh_quotient", bus.out_quotient, 8'd3);
    checkOutput("rst_fresh_remainder", bus.out_remainder, 8'd0);
    checkOutput("rst_fresh_div_by_zero", bus.out_div_by_zero, 1'b0);
    waitIdle("rst_fresh_drained", 20);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Backstop so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
